// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - first-word-fall-through queue of fetch responses
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      s_tvalid,
  input  imem_rsp_t s_tdata,
  output logic      m_tvalid,
  input  logic      m_tready,
  output imem_rsp_t m_tdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  imem_rsp_t [DEPTH-1:0] entries_q, entries_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  // The responder never has more accepted requests than DEPTH, so a push
  // can never find the queue full.
  assign push     = s_tvalid;
  assign pop      = m_tvalid && m_tready;
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = entries_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      entries_d[wr_ptr_q] = s_tdata;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state; storage is cleared too so the head reads as zero after reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency, in-order instruction fetch responder with program-load port
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR       = 64'h8000_0000,
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [63:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_data,
  output logic                           rsp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) * 64'(INSTR_BYTES);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             req_fire, rsp_fire;
  logic [63:0]      offset;
  logic [IDX_W-1:0] rd_idx;
  imem_rsp_t        rd_rsp;
  logic             push_valid;
  imem_rsp_t        push_rsp;
  imem_rsp_t        head_rsp;

  assign req_ready = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_data  = head_rsp.data;
  assign rsp_err   = head_rsp.err;

  // Address decode and array read; range check runs on the full 64-bit
  // offset before it is cut down to a word index
  always_comb begin
    offset = req_addr - BASE_ADDR;
    rd_idx = offset[IDX_W+1:2];
    rd_rsp = '0;
    if ((req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) || (offset >= MEM_BYTES)) begin
      rd_rsp.err = 1'b1;
    end else begin
      rd_rsp.data = mem_q[rd_idx];
    end
  end

  // Program-load port; the array is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Outstanding count tracks accepted requests not yet consumed
  always_comb begin
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Outstanding count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) outstanding_q <= '0;
    else         outstanding_q <= outstanding_d;
  end

  // The queue's registered head adds one cycle, so the pipeline carries
  // LATENCY-1 stages and a single-cycle latency pushes straight in.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = req_fire;
    assign push_rsp   = rd_rsp;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;

    logic      [STAGES-1:0] pipe_valid_q, pipe_valid_d;
    imem_rsp_t [STAGES-1:0] pipe_rsp_q, pipe_rsp_d;

    // Shift the valid-tagged responses one stage per cycle
    always_comb begin
      pipe_valid_d[0] = req_fire;
      pipe_rsp_d[0]   = rd_rsp;
      for (int i = 1; i < STAGES; i++) begin
        pipe_valid_d[i] = pipe_valid_q[i-1];
        pipe_rsp_d[i]   = pipe_rsp_q[i-1];
      end
    end

    // Pipeline registers; reset drops everything in flight
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        pipe_valid_q <= '0;
        pipe_rsp_q   <= '0;
      end else begin
        pipe_valid_q <= pipe_valid_d;
        pipe_rsp_q   <= pipe_rsp_d;
      end
    end

    assign push_valid = pipe_valid_q[STAGES-1];
    assign push_rsp   = pipe_rsp_q[STAGES-1];
  end

  imem_rsp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .s_tvalid(push_valid),
    .s_tdata (push_rsp),
    .m_tvalid(rsp_valid),
    .m_tready(rsp_ready),
    .m_tdata (head_rsp)
  );

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;

  localparam logic [31:0] W0    = 32'h0000_0093;
  localparam logic [31:0] W1    = 32'h0010_0113;
  localparam logic [31:0] W2    = 32'h0020_0193;
  localparam logic [31:0] W5    = 32'h1111_1111;
  localparam logic [31:0] WLAST = 32'hCAFE_F00D;
  localparam logic [31:0] WNEW  = 32'hDEAD_BEEF;

  logic        clk, resetn;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  int vectors, miscompares;

  logic [63:0] addr_tbl [8];
  logic [31:0] obs_data [8];
  logic        obs_err  [8];
  int          obs_cyc  [8];
  int          acc_cyc  [8];
  int          obs_n;

  imem_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_word(input logic [9:0] idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Issues addr_tbl[0..n-1] back to back with rsp_ready=1, recording when
  // each request is accepted and when each response is seen.
  task automatic run_stream(input int n);
    int issued, cyc;
    issued    = 0;
    obs_n     = 0;
    cyc       = 0;
    rsp_ready = 1'b1;
    while ((issued < n || obs_n < n) && cyc < 40) begin
      if (rsp_valid && obs_n < 8) begin
        obs_data[obs_n] = rsp_data;
        obs_err[obs_n]  = rsp_err;
        obs_cyc[obs_n]  = cyc;
        obs_n++;
      end
      req_valid = (issued < n);
      req_addr  = (issued < n) ? addr_tbl[issued] : 64'h0;
      if (req_valid && req_ready) begin
        acc_cyc[issued] = cyc;
        issued++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++;
    if (rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); end
    vectors++;
    if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    resetn = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_single_fetch;
    load_word(10'd0, W0);
    load_word(10'd1, W1);
    load_word(10'd2, W2);
    load_word(10'd5, W5);
    load_word(10'd1023, WLAST);
    addr_tbl[0] = 64'h8000_0000;
    run_stream(1);
    vectors++;
    if (obs_n !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", obs_n); end
    else begin
      vectors++;
      if (obs_cyc[0] - acc_cyc[0] !== 2) begin miscompares++; $display("FAIL single_latency: got %0d expected 2", obs_cyc[0] - acc_cyc[0]); end
      vectors++;
      if (obs_data[0] !== W0 || obs_err[0] !== 1'b0) begin miscompares++; $display("FAIL single_data: got %h/%b expected %h/0", obs_data[0], obs_err[0], W0); end
    end
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_dup: got rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_errors;
    addr_tbl[0] = 64'h8000_0002;
    addr_tbl[1] = 64'h7FFF_FFFC;
    addr_tbl[2] = 64'h8000_1000;
    addr_tbl[3] = 64'hFFFF_FFFF_FFFF_FFFC;
    addr_tbl[4] = 64'h8000_0FFC;
    run_stream(5);
    vectors++;
    if (obs_n !== 5) begin miscompares++; $display("FAIL err_count: got %0d expected 5", obs_n); end
    for (int i = 0; i < 4 && i < obs_n; i++) begin
      vectors++;
      if (obs_err[i] !== 1'b1 || obs_data[i] !== 32'h0) begin
        miscompares++;
        $display("FAIL err_rsp%0d: got %h/%b expected 00000000/1", i, obs_data[i], obs_err[i]);
      end
    end
    if (obs_n == 5) begin
      vectors++;
      if (obs_err[4] !== 1'b0 || obs_data[4] !== WLAST) begin miscompares++; $display("FAIL last_word: got %h/%b expected %h/0", obs_data[4], obs_err[4], WLAST); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [3];
    exp_d[0] = W0; exp_d[1] = W1; exp_d[2] = W2;
    addr_tbl[0] = 64'h8000_0000;
    addr_tbl[1] = 64'h8000_0004;
    addr_tbl[2] = 64'h8000_0008;
    run_stream(3);
    vectors++;
    if (obs_n !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", obs_n); end
    for (int i = 0; i < 3 && i < obs_n; i++) begin
      vectors++;
      if (obs_data[i] !== exp_d[i] || obs_err[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_data%0d: got %h/%b expected %h/0", i, obs_data[i], obs_err[i], exp_d[i]);
      end
      vectors++;
      if (obs_cyc[i] !== acc_cyc[0] + 2 + i || acc_cyc[i] !== acc_cyc[0] + i) begin
        miscompares++;
        $display("FAIL b2b_timing%0d: got acc %0d rsp %0d expected acc %0d rsp %0d", i, acc_cyc[i], obs_cyc[i], acc_cyc[0] + i, acc_cyc[0] + 2 + i);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_d [4];
    int acc, got;
    exp_d[0] = W0; exp_d[1] = W1; exp_d[2] = W2; exp_d[3] = W5;
    addr_tbl[0] = 64'h8000_0000;
    addr_tbl[1] = 64'h8000_0004;
    addr_tbl[2] = 64'h8000_0008;
    addr_tbl[3] = 64'h8000_0014;
    acc       = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) begin
        vectors++;
        if (rsp_data !== W0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL bp_hold_c%0d: got %h/%b expected %h/0", c, rsp_data, rsp_err, W0); end
      end
      req_valid = 1'b1;
      req_addr  = addr_tbl[acc < 4 ? acc : 3];
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    vectors++;
    if (acc !== 4) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready_low: got %b expected 0", req_ready); end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== W0) begin miscompares++; $display("FAIL bp_head_stable: got %b/%h expected 1/%h", rsp_valid, rsp_data, W0); end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin
        vectors++;
        if (got >= 4 || rsp_data !== exp_d[got < 4 ? got : 3] || rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_drain%0d: got %h/%b expected %h/0", got, rsp_data, rsp_err, exp_d[got < 4 ? got : 3]);
        end
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got !== 4) begin miscompares++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_req_ready_back: got %b expected 1", req_ready); end
  endtask

  task automatic test_load_collision;
    rsp_ready = 1'b1;
    load_en   = 1'b1;
    load_addr = 10'd5;
    load_data = WNEW;
    req_valid = 1'b1;
    req_addr  = 64'h8000_0014;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL coll_req_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    load_en   = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== W5 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_old_data: got %b/%h/%b expected 1/%h/0", rsp_valid, rsp_data, rsp_err, W5);
    end
    @(negedge clk);
    addr_tbl[0] = 64'h8000_0014;
    run_stream(1);
    vectors++;
    if (obs_n !== 1 || obs_data[0] !== WNEW) begin miscompares++; $display("FAIL coll_new_data: got %0d rsp %h expected 1 rsp %h", obs_n, obs_data[0], WNEW); end
  endtask

  task automatic test_reset_inflight;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'h8000_0000 + 64'(4 * i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid: got %b expected 1", rsp_valid); end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_async: got valid %b data %h ready %b expected 0/00000000/1", rsp_valid, rsp_data, req_ready);
    end
    @(negedge clk);
    resetn    = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stale_c%0d: got %b expected 0", c, rsp_valid); end
    end
    addr_tbl[0] = 64'h8000_0000;
    addr_tbl[1] = 64'h8000_0014;
    run_stream(2);
    vectors++;
    if (obs_n !== 2 || obs_data[0] !== W0 || obs_data[1] !== WNEW) begin
      miscompares++;
      $display("FAIL rst_mem_kept: got %0d rsp %h %h expected 2 rsp %h %h", obs_n, obs_data[0], obs_data[1], W0, WNEW);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_single_fetch;
    test_errors;
    test_back_to_back;
    test_backpressure;
    test_load_collision;
    test_reset_inflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 64'h8000_0000: byte address of memory word 0, equal to the core reset vector.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit instruction words; power of two.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to the earliest rsp_valid; range 1..4.
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unconsumed requests; range 1..8.
REQ-005 Port clk, input, 1: clock; reset resetn, asynchronous, active-low.
REQ-006 Port resetn, input, 1: asynchronous active-low reset.
REQ-007 Port req_valid, input, 1: fetch request present.
REQ-008 Port req_ready, output, 1: responder can accept a request.
REQ-009 Port req_addr, input, 64: fetch byte address (pc).
REQ-010 Port rsp_valid, output, 1: response present.
REQ-011 Port rsp_ready, input, 1: core consumes the response.
REQ-012 Port rsp_data, output, 32: instruction word.
REQ-013 Port rsp_err, output, 1: access fault (misaligned or out of range).
REQ-014 Port load_en, input, 1: program-load write strobe.
REQ-015 Port load_addr, input, log2(DEPTH_WORDS): word index to write.
REQ-016 Port load_data, input, 32: word to write.

Function
REQ-017 A request is accepted on a rising clk edge with req_valid && req_ready.
REQ-018 req_ready = (outstanding < MAX_OUTSTANDING); outstanding counts in-flight plus queued responses and is combinational from registered state only.
REQ-019 A request accepted at edge N makes its response visible (rsp_valid=1) no earlier than the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles later when the queue is empty and rsp_ready=1.
REQ-020 Responses return strictly in acceptance order.
REQ-021 A response is consumed on an edge with rsp_valid && rsp_ready; outstanding decrements by one.
REQ-022 Acceptance and consumption on the same edge leave outstanding unchanged.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_data and rsp_err hold stable.
REQ-024 Error when req_addr[1:0]!=0 or req_addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): rsp_err=1, rsp_data=32'h0000_0000; error requests follow identical latency and ordering.
REQ-025 Non-error: rsp_err=0, rsp_data = mem[(req_addr-BASE_ADDR)>>2]; address subtraction is 64-bit and unsigned; out-of-range detection precedes index truncation.
REQ-026 The memory word is read at acceptance; a load_en write to the same index on the acceptance edge is not visible to that request (old data returned), but is visible to requests accepted on later edges.
REQ-027 load_en writes take effect on the edge they are sampled, independent of fetch traffic and backpressure.
REQ-028 Outstanding never exceeds MAX_OUTSTANDING; no response is dropped or duplicated.

Reset
REQ-029 resetn low asynchronously clears: req_ready=0 is not required; outstanding=0, so req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-030 Reset during operation discards all in-flight and queued responses; the first response after deassertion belongs to the first request accepted after deassertion.
REQ-031 Memory array contents are not affected by reset.

Structure
REQ-032 Shared package imem_pkg holds the fetch response struct type {data[31:0], err} and the constant INSTR_BYTES=4.
REQ-033 One sub-module, imem_rsp_fifo: a MAX_OUTSTANDING-deep, synchronous, first-word-fall-through queue of response structs; the latency pipeline is a valid-tagged shift register in imem_responder.

Verification
REQ-034 Reset, load mem[0]=32'h0000_0093, then fetch 64'h8000_0000 with rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance, rsp_data=32'h0000_0093, rsp_err=0.
REQ-035 Fetch 64'h8000_0002 and 64'h7FFF_FFFC and 64'h8000_1000 -> three responses in order, each rsp_err=1 and rsp_data=0.
REQ-036 rsp_ready=0, req_valid held 1 for 8 cycles -> exactly 4 accepted, req_ready=0 afterwards, rsp_valid/rsp_data stable; raise rsp_ready -> 4 in-order responses, then req_ready returns to 1.
REQ-037 Back-to-back fetches 0x8000_0000, 0x8000_0004, 0x8000_0008 with rsp_ready=1 -> one response per cycle, data mem[0], mem[1], mem[2], outstanding constant at 2.
REQ-038 load_en to index 5 with 32'hDEAD_BEEF on the same edge as fetch 0x8000_0014 -> old word returned; next fetch of 0x8000_0014 returns 32'hDEAD_BEEF.
REQ-039 Assert resetn low with 3 outstanding -> rsp_valid=0 immediately; after release, req_ready=1, no stale response appears, memory contents preserved.
